// File: rtl/sysid_checker_if.sv
// ----------------------------------------------------------------------------
// | Module   : sysid_checker_if                                              |
// | Brief    : Avalon-MM read-only bus between the checker and sysid slave   |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`default_nettype none

interface sysid_checker_if;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_read,
        input  m_waitrequest,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_waitrequest,
        output m_readdata
    );
endinterface

`default_nettype wire

// File: rtl/sysid_checker.sv
// ----------------------------------------------------------------------------
// | Module   : sysid_checker                                                 |
// | Brief    : Reads the sysid ID and timestamp words over Avalon-MM and     |
// |            compares them against build-time values (pass/fail/timeout). |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`default_nettype none

module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd26,
    parameter logic [31:0] EXPECTED_TS    = 32'd1718298719,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    input  wire logic        start,
    sysid_checker_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic             id_ok,
    output logic             ts_ok,
    output logic             timeout,
    output logic [31:0]      id_value,
    output logic [31:0]      ts_value
);

    // Stall count at which the next stalled edge aborts the read.
    localparam logic [15:0] c_stall_last = 16'(TIMEOUT_CYCLES - 1);
    // Latency count value on the cycle that carries valid read data.
    localparam logic [1:0]  c_lat_last   = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_stall;
    logic [1:0]  r_lat;
    logic        r_auto;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic        w_read;
    logic        w_accept;
    logic        w_stalled;
    logic        w_expired;
    logic        w_lat_hit;
    logic        w_launch;
    logic        w_cap_id;
    logic        w_cap_ts;
    logic        w_abort;
    logic        w_check;

    // Bus strobes are decoded straight from the state so that a back-to-back
    // ID/timestamp pair keeps m_read high while only the address flips.
    assign w_read        = (r_state == RD_ID) || (r_state == RD_TS);
    assign bus.m_read    = w_read;
    assign bus.m_address = (r_state == RD_TS) || (r_state == LAT_TS);

    assign w_accept  = w_read && !bus.m_waitrequest;
    assign w_stalled = w_read &&  bus.m_waitrequest;
    assign w_expired = w_stalled && (r_stall == c_stall_last);
    assign w_lat_hit = (r_lat == c_lat_last);

    assign busy     = (r_state != IDLE) && (r_state != DONE);
    assign done     = (r_state == DONE);
    assign id_ok    = r_id_ok;
    assign ts_ok    = r_ts_ok;
    assign timeout  = r_timeout;
    assign id_value = r_id_value;
    assign ts_value = r_ts_value;

    // Next-state decode plus one-cycle capture/abort/compare strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_cap_id    = 1'b0;
        w_cap_ts    = 1'b0;
        w_abort     = 1'b0;
        w_check     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                // A start coinciding with the auto trigger is still one launch.
                if (start || r_auto) begin
                    w_launch    = 1'b1;
                    w_state_nxt = RD_ID;
                end
            end
            RD_ID: begin
                if (w_accept) begin
                    if (READ_LATENCY == 0) begin
                        w_cap_id    = 1'b1;
                        w_state_nxt = RD_TS;
                    end else begin
                        w_state_nxt = LAT_ID;
                    end
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            LAT_ID: begin
                if (w_lat_hit) begin
                    w_cap_id    = 1'b1;
                    w_state_nxt = RD_TS;
                end
            end
            RD_TS: begin
                if (w_accept) begin
                    if (READ_LATENCY == 0) begin
                        w_cap_ts    = 1'b1;
                        w_state_nxt = CHECK;
                    end else begin
                        w_state_nxt = LAT_TS;
                    end
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            LAT_TS: begin
                if (w_lat_hit) begin
                    w_cap_ts    = 1'b1;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                w_check     = 1'b1;
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and result registers; reset drops any partial result.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_stall    <= 16'd0;
            r_lat      <= 2'd0;
            r_auto     <= AUTO_START;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            // Auto trigger is one-shot per reset release.
            r_auto  <= 1'b0;

            // Counts consecutive stalled cycles; any non-stalled cycle rearms it.
            if (w_stalled && !w_expired) begin
                r_stall <= r_stall + 16'd1;
            end else begin
                r_stall <= 16'd0;
            end

            // Counts cycles since the accept edge while waiting for read data.
            if ((r_state == LAT_ID) || (r_state == LAT_TS)) begin
                r_lat <= r_lat + 2'd1;
            end else begin
                r_lat <= 2'd0;
            end

            // Old words are wiped on launch so an aborted check reports 0
            // for anything it never read.
            if (w_launch) begin
                r_id_ok    <= 1'b0;
                r_ts_ok    <= 1'b0;
                r_timeout  <= 1'b0;
                r_id_value <= 32'd0;
                r_ts_value <= 32'd0;
            end
            if (w_cap_id) begin
                r_id_value <= bus.m_readdata;
            end
            if (w_cap_ts) begin
                r_ts_value <= bus.m_readdata;
            end
            if (w_abort) begin
                r_timeout <= 1'b1;
                r_id_ok   <= 1'b0;
                r_ts_ok   <= 1'b0;
            end
            if (w_check) begin
                r_id_ok <= (r_id_value == EXPECTED_ID);
                r_ts_ok <= (r_ts_value == EXPECTED_TS);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sysid_checker.sv
// ----------------------------------------------------------------------------
// | Module   : tb_sysid_checker                                              |
// | Brief    : Three checker instances (default / latency-2 + short timeout |
// |            / no auto start) driven by a scripted sysid slave model.     |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sysid_checker;

    localparam int          c_n      = 3;
    localparam logic [31:0] c_exp_id = 32'd26;
    localparam logic [31:0] c_exp_ts = 32'd1718298719;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [c_n-1:0] rstn_a;
    logic [c_n-1:0] start_a;
    int             plan_id [c_n];
    int             plan_ts [c_n];
    logic [31:0]    word_id [c_n];
    logic [31:0]    word_ts [c_n];

    wire  [c_n-1:0] w_busy, w_done, w_idok, w_tsok, w_tmo, w_mread, w_maddr;
    wire  [31:0]    w_idv    [c_n];
    wire  [31:0]    w_tsv    [c_n];
    wire  [31:0]    w_acc_id [c_n];
    wire  [31:0]    w_acc_ts [c_n];
    wire  [31:0]    w_moved  [c_n];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < c_n; g++) begin : g_dut
        localparam int c_rl = (g == 1) ? 2 : 0;
        sysid_checker_if bus ();
        int acc_id;
        int acc_ts;
        int moved;

        sysid_checker #(
            .EXPECTED_ID    (c_exp_id),
            .EXPECTED_TS    (c_exp_ts),
            .READ_LATENCY   (c_rl),
            .TIMEOUT_CYCLES ((g == 1) ? 8 : 255),
            .AUTO_START     ((g == 2) ? 1'b0 : 1'b1)
        ) u_dut (
            .clock    (clock),
            .reset_n  (rstn_a[g]),
            .start    (start_a[g]),
            .bus      (bus.master),
            .busy     (w_busy[g]),
            .done     (w_done[g]),
            .id_ok    (w_idok[g]),
            .ts_ok    (w_tsok[g]),
            .timeout  (w_tmo[g]),
            .id_value (w_idv[g]),
            .ts_value (w_tsv[g])
        );

        assign w_mread[g]  = bus.m_read;
        assign w_maddr[g]  = bus.m_address;
        assign w_acc_id[g] = acc_id;
        assign w_acc_ts[g] = acc_ts;
        assign w_moved[g]  = moved;

        // Slave: each new request stalls for its planned cycle count, then is
        // accepted; data appears c_rl cycles after the accept, noise elsewhere.
        initial begin : slave
            bit in_req;
            bit req_addr;
            bit lat_addr;
            int left;
            int lat;
            in_req = 1'b0; req_addr = 1'b0; lat_addr = 1'b0; left = 0; lat = 0;
            acc_id = 0; acc_ts = 0; moved = 0;
            bus.m_waitrequest = 1'b0;
            bus.m_readdata    = 32'd0;
            forever begin
                @(negedge clock);
                bus.m_readdata = $urandom;
                if (lat > 0) begin
                    lat--;
                    if (lat == 0) bus.m_readdata = lat_addr ? word_ts[g] : word_id[g];
                end
                if (!bus.m_read) begin
                    in_req = 1'b0;
                    bus.m_waitrequest = 1'($urandom);
                end else begin
                    if (!in_req) begin
                        in_req   = 1'b1;
                        req_addr = bus.m_address;
                        left     = req_addr ? plan_ts[g] : plan_id[g];
                    end else if (bus.m_address != req_addr) begin
                        moved++;
                    end
                    if (left > 0) begin
                        left--;
                        bus.m_waitrequest = 1'b1;
                    end else begin
                        bus.m_waitrequest = 1'b0;
                        in_req = 1'b0;
                        if (req_addr) acc_ts++; else acc_id++;
                        if (c_rl == 0) begin
                            bus.m_readdata = req_addr ? word_ts[g] : word_id[g];
                        end else begin
                            lat      = c_rl;
                            lat_addr = req_addr;
                        end
                    end
                end
            end
        end
    end

    function automatic int rl_of(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic int to_of(input int k);
        return (k == 1) ? 8 : 255;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_cleared(input int k, input string nm);
        chk($sformatf("u%0d %s flags", k, nm),
            {25'd0, w_busy[k], w_done[k], w_idok[k], w_tsok[k], w_tmo[k], w_mread[k], w_maddr[k]}, 32'd0);
        chk($sformatf("u%0d %s id_value", k, nm), w_idv[k], 32'd0);
        chk($sformatf("u%0d %s ts_value", k, nm), w_tsv[k], 32'd0);
    endtask

    // Reference: a read times out iff its stall count reaches the timeout;
    // each completed read costs 1 + stalls + latency cycles, plus one cycle
    // to launch and one to compare.
    task automatic run_check(input int k, input int sid, input int sts,
                             input logic [31:0] wid, input logic [31:0] wts, input string nm);
        int rl, to, exp_lat, n, a_id0, a_ts0, mv0;
        bit t_id, t_ts, t_any;
        rl    = rl_of(k);
        to    = to_of(k);
        t_id  = (sid >= to);
        t_ts  = !t_id && (sts >= to);
        t_any = t_id || t_ts;
        if (t_id)      exp_lat = 1 + to;
        else if (t_ts) exp_lat = 2 + sid + rl + to;
        else           exp_lat = 4 + sid + sts + 2 * rl;

        plan_id[k] = sid; plan_ts[k] = sts;
        word_id[k] = wid; word_ts[k] = wts;
        a_id0 = w_acc_id[k]; a_ts0 = w_acc_ts[k]; mv0 = w_moved[k];

        start_a[k] = 1'b1;
        tick();
        start_a[k] = 1'b0;
        n = 1;
        while (!w_done[k] && n < exp_lat + 50) begin
            tick();
            n++;
        end
        chk($sformatf("u%0d %s done latency", k, nm), n, exp_lat);
        chk($sformatf("u%0d %s done", k, nm), w_done[k], 1'b1);
        chk($sformatf("u%0d %s busy", k, nm), w_busy[k], 1'b0);
        chk($sformatf("u%0d %s m_read", k, nm), w_mread[k], 1'b0);
        chk($sformatf("u%0d %s timeout", k, nm), w_tmo[k], t_any);
        chk($sformatf("u%0d %s id_value", k, nm), w_idv[k], t_id ? 32'd0 : wid);
        chk($sformatf("u%0d %s ts_value", k, nm), w_tsv[k], t_any ? 32'd0 : wts);
        chk($sformatf("u%0d %s id_ok", k, nm), w_idok[k], !t_any && (wid == c_exp_id));
        chk($sformatf("u%0d %s ts_ok", k, nm), w_tsok[k], !t_any && (wts == c_exp_ts));
        chk($sformatf("u%0d %s id reads", k, nm), w_acc_id[k] - a_id0, t_id ? 0 : 1);
        chk($sformatf("u%0d %s ts reads", k, nm), w_acc_ts[k] - a_ts0, t_any ? 0 : 1);
        chk($sformatf("u%0d %s addr stable", k, nm), w_moved[k] - mv0, 0);
    endtask

    function automatic logic [31:0] pick_word(input logic [31:0] good);
        case ($urandom_range(0, 2))
            0:       return good;
            1:       return good ^ (32'd1 << $urandom_range(0, 31));
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int d0, d1, idle_hits, n;
        bit seen;
        rstn_a  = '0;
        start_a = '0;
        for (int k = 0; k < c_n; k++) begin
            plan_id[k] = 0; plan_ts[k] = 0;
            word_id[k] = c_exp_id; word_ts[k] = c_exp_ts;
        end
        repeat (3) tick();
        for (int k = 0; k < c_n; k++) chk_cleared(k, "reset");

        // Auto start on u0/u1, u2 must stay idle for 100 cycles.
        rstn_a = '1;
        d0 = -1; d1 = -1; idle_hits = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (w_mread[2] || w_busy[2]) idle_hits++;
            if (w_done[0] && d0 < 0) d0 = i;
            if (w_done[1] && d1 < 0) d1 = i;
        end
        chk("u2 idle without start", idle_hits, 0);
        chk("u0 auto done latency", d0, 4);
        chk("u1 auto done latency", d1, 8);
        chk("u0 auto ok", {w_idok[0], w_tsok[0], w_tmo[0]}, 3'b110);
        chk("u1 auto ok", {w_idok[1], w_tsok[1], w_tmo[1]}, 3'b110);
        chk("u0 no retrigger", {w_done[0], w_busy[0]}, 2'b10);

        // Directed cases.
        run_check(0, 0, 0, c_exp_id, c_exp_ts, "pass");
        run_check(0, 0, 0, 32'd27, c_exp_ts, "id27");
        run_check(0, 2, 1, c_exp_id, c_exp_ts ^ 32'h8000_0000, "ts_msb");
        run_check(1, 3, 3, c_exp_id, c_exp_ts, "lat2 stall3");
        run_check(1, 1000, 0, c_exp_id, c_exp_ts, "stuck id");
        run_check(1, 7, 8, c_exp_id, c_exp_ts, "ts timeout edge");
        run_check(2, 0, 0, c_exp_id, c_exp_ts, "manual");

        // Randomised checks across all three instances.
        for (int i = 0; i < 30; i++) begin
            int k, smax;
            k    = $urandom_range(0, c_n - 1);
            smax = (k == 1) ? 10 : 4;
            run_check(k, $urandom_range(0, smax), $urandom_range(0, smax),
                      pick_word(c_exp_id), pick_word(c_exp_ts), $sformatf("rand%0d", i));
        end

        // start during RD_TS is ignored: total latency is the undisturbed one.
        plan_id[1] = 0; plan_ts[1] = 5;
        word_id[1] = c_exp_id; word_ts[1] = c_exp_ts;
        start_a[1] = 1'b1;
        tick();
        start_a[1] = 1'b0;
        n = 1; seen = 1'b0;
        while (!seen && n < 50) begin
            tick();
            n++;
            if (w_mread[1] && w_maddr[1]) seen = 1'b1;
        end
        chk("u1 reached RD_TS", seen, 1'b1);
        start_a[1] = 1'b1;
        tick();
        n++;
        start_a[1] = 1'b0;
        while (!w_done[1] && n < 80) begin
            tick();
            n++;
        end
        chk("u1 start ignored latency", n, 13);
        repeat (3) tick();
        chk("u1 start not queued", {w_done[1], w_busy[1], w_idok[1], w_tsok[1]}, 4'b1011);

        // Reset during LAT_ID clears everything; auto start reruns.
        plan_id[1] = 0; plan_ts[1] = 0;
        start_a[1] = 1'b1;
        tick();
        start_a[1] = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            tick();
            n++;
            if (w_busy[1] && !w_mread[1]) seen = 1'b1;
        end
        chk("u1 reached LAT_ID", seen, 1'b1);
        rstn_a[1] = 1'b0;
        tick();
        chk_cleared(1, "mid reset");
        rstn_a[1] = 1'b1;
        n = 0;
        while (!w_done[1] && n < 50) begin
            tick();
            n++;
        end
        chk("u1 rerun latency", n, 8);
        chk("u1 rerun ok", {w_idok[1], w_tsok[1], w_tmo[1]}, 3'b110);
        chk("u1 rerun id_value", w_idv[1], c_exp_id);
        chk("u1 rerun ts_value", w_tsv[1], c_exp_ts);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
